sha256_msg_sched_ctrl: RTL and testbench

SHA256_MSG_SCHED_CTRL -- requirements
Module: sha256_msg_sched_ctrl

---
 rtl/sha256_msg_sched_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_sha256_msg_sched_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_sched_ctrl.sv
// SHA-256 message scheduler control: loads one padded 512-bit block from a byte
// memory, then streams W[t]/K[t] to the compression core over a valid/ready handshake.
module sha256_msg_sched_ctrl #(
  parameter int unsigned MAX_MESSAGE_LENGTH = 55,
  parameter int unsigned NUMBER_OF_Ks       = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        xxx__dut__go,
  input  logic [6:0]  xxx__dut__msg_length,
  output logic [5:0]  dut__msg__address,
  output logic        dut__msg__enable,
  output logic        dut__msg__write,
  input  logic [7:0]  msg__dut__data,
  output logic [5:0]  dut__kmem__address,
  output logic        dut__kmem__enable,
  output logic        dut__kmem__write,
  input  logic [31:0] kmem__dut__data,
  output logic [31:0] sched__core__w,
  output logic [31:0] sched__core__k,
  output logic [5:0]  sched__core__round,
  output logic        sched__core__valid,
  input  logic        core__sched__ready,
  output logic        sched__xxx__done
);

  localparam int unsigned WIN_DEPTH = 16;
  localparam logic [6:0]  MAX_LEN    = 7'(MAX_MESSAGE_LENGTH);
  localparam logic [5:0]  LAST_ROUND = 6'(NUMBER_OF_Ks - 1);
  localparam logic [5:0]  LAST_BYTE  = 6'd63;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FETCH,
    PRESENT,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  len_q, len_d;
  logic [5:0]  b_q, b_d;
  logic [5:0]  t_q, t_d;
  logic [31:0] win_q [WIN_DEPTH];
  logic [31:0] win_d [WIN_DEPTH];
  logic [31:0] w_q, w_d;
  logic [31:0] k_q, k_d;
  logic [5:0]  round_q, round_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic [5:0]  msg_addr_q, msg_addr_d;
  logic        msg_en_q, msg_en_d;
  logic [5:0]  kmem_addr_q, kmem_addr_d;
  logic        kmem_en_q, kmem_en_d;

  logic [6:0]  len_clamp;
  logic [5:0]  next_b;
  logic [15:0] len_bits;
  logic [7:0]  byte_val;
  logic [31:0] w_next;

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    b_d         = b_q;
    t_d         = t_q;
    win_d       = win_q;
    w_d         = w_q;
    k_d         = k_q;
    round_d     = round_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    msg_addr_d  = '0;
    msg_en_d    = 1'b0;
    kmem_addr_d = '0;
    kmem_en_d   = 1'b0;

    len_clamp = (xxx__dut__msg_length > MAX_LEN) ? MAX_LEN : xxx__dut__msg_length;
    next_b    = b_q + 6'd1;
    len_bits  = {6'b0, len_q, 3'b0};

    // Block byte b: message data while b < len, then 0x80, zeros, 16-bit bit length
    if ({1'b0, b_q} < len_q) begin
      byte_val = msg__dut__data;
    end else if ({1'b0, b_q} == len_q) begin
      byte_val = 8'h80;
    end else if (b_q == 6'd62) begin
      byte_val = len_bits[15:8];
    end else if (b_q == LAST_BYTE) begin
      byte_val = len_bits[7:0];
    end else begin
      byte_val = 8'h00;
    end

    // Window holds W[t-16..t-1] once sixteen rounds have shifted through
    if (t_q < 6'd16) begin
      w_next = win_q[0];
    end else begin
      w_next = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];
    end

    unique case (state_q)
      IDLE: begin
        if (xxx__dut__go) begin
          state_d  = LOAD;
          len_d    = len_clamp;
          b_d      = '0;
          t_d      = '0;
          msg_en_d = (len_clamp != 7'd0);
        end
      end
      LOAD: begin
        unique case (b_q[1:0])
          2'd0: win_d[b_q[5:2]][31:24] = byte_val;
          2'd1: win_d[b_q[5:2]][23:16] = byte_val;
          2'd2: win_d[b_q[5:2]][15:8]  = byte_val;
          default: win_d[b_q[5:2]][7:0] = byte_val;
        endcase
        if (b_q == LAST_BYTE) begin
          state_d   = FETCH;
          t_d       = '0;
          kmem_en_d = 1'b1;
        end else begin
          b_d      = next_b;
          msg_en_d = ({1'b0, next_b} < len_q);
          if ({1'b0, next_b} < len_q) begin
            msg_addr_d = next_b;
          end
        end
      end
      FETCH: begin
        state_d = PRESENT;
        w_d     = w_next;
        k_d     = kmem__dut__data;
        round_d = t_q;
        valid_d = 1'b1;
      end
      PRESENT: begin
        if (core__sched__ready) begin
          for (int unsigned i = 0; i < WIN_DEPTH - 1; i++) begin
            win_d[4'(i)] = win_q[4'(i + 1)];
          end
          win_d[WIN_DEPTH - 1] = w_q;
          valid_d = 1'b0;
          if (t_q == LAST_ROUND) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d     = FETCH;
            t_d         = t_q + 6'd1;
            kmem_en_d   = 1'b1;
            kmem_addr_d = t_q + 6'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      b_q         <= '0;
      t_q         <= '0;
      for (int unsigned i = 0; i < WIN_DEPTH; i++) begin
        win_q[4'(i)] <= '0;
      end
      w_q         <= '0;
      k_q         <= '0;
      round_q     <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      msg_addr_q  <= '0;
      msg_en_q    <= 1'b0;
      kmem_addr_q <= '0;
      kmem_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      b_q         <= b_d;
      t_q         <= t_d;
      win_q       <= win_d;
      w_q         <= w_d;
      k_q         <= k_d;
      round_q     <= round_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      msg_addr_q  <= msg_addr_d;
      msg_en_q    <= msg_en_d;
      kmem_addr_q <= kmem_addr_d;
      kmem_en_q   <= kmem_en_d;
    end
  end

  assign dut__msg__address  = msg_addr_q;
  assign dut__msg__enable   = msg_en_q;
  assign dut__msg__write    = 1'b0;
  assign dut__kmem__address = kmem_addr_q;
  assign dut__kmem__enable  = kmem_en_q;
  assign dut__kmem__write   = 1'b0;
  assign sched__core__w     = w_q;
  assign sched__core__k     = k_q;
  assign sched__core__round = round_q;
  assign sched__core__valid = valid_q;
  assign sched__xxx__done   = done_q;

endmodule

// File: tb/tb_sha256_msg_sched_ctrl.sv
// Directed bench for sha256_msg_sched_ctrl: vector table of padded-block runs,
// plus stall, go-noise and mid-run reset sequences against a behavioural schedule model.
module tb_sha256_msg_sched_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic [6:0]  msg_length = '0;
  logic        ready = 1'b1;
  logic [5:0]  dut__msg__address;
  logic        dut__msg__enable;
  logic        dut__msg__write;
  logic [7:0]  msg__dut__data;
  logic [5:0]  dut__kmem__address;
  logic        dut__kmem__enable;
  logic        dut__kmem__write;
  logic [31:0] kmem__dut__data;
  logic [31:0] sched__core__w;
  logic [31:0] sched__core__k;
  logic [5:0]  sched__core__round;
  logic        sched__core__valid;
  logic        sched__xxx__done;

  always #5 clk = ~clk;

  sha256_msg_sched_ctrl dut (
    .clk                  (clk),
    .reset                (reset),
    .xxx__dut__go         (go),
    .xxx__dut__msg_length (msg_length),
    .dut__msg__address    (dut__msg__address),
    .dut__msg__enable     (dut__msg__enable),
    .dut__msg__write      (dut__msg__write),
    .msg__dut__data       (msg__dut__data),
    .dut__kmem__address   (dut__kmem__address),
    .dut__kmem__enable    (dut__kmem__enable),
    .dut__kmem__write     (dut__kmem__write),
    .kmem__dut__data      (kmem__dut__data),
    .sched__core__w       (sched__core__w),
    .sched__core__k       (sched__core__k),
    .sched__core__round   (sched__core__round),
    .sched__core__valid   (sched__core__valid),
    .core__sched__ready   (ready),
    .sched__xxx__done     (sched__xxx__done)
  );

  logic [7:0]  msg_mem [64];
  logic [31:0] kmem    [64];
  assign msg__dut__data  = dut__msg__enable  ? msg_mem[dut__msg__address] : 8'h00;
  assign kmem__dut__data = dut__kmem__enable ? kmem[dut__kmem__address]   : 32'h0;

  typedef struct {
    string       name;
    int          len;
    bit          abc;
    logic [7:0]  fill;
    int          exp_reads;
    logic [31:0] w0, w13, w14, w15, w16, w17;
  } vec_t;

  vec_t        vecs [4];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mw     [64];
  logic [31:0] cap_w  [64];
  logic [31:0] cap_k  [64];
  logic [31:0] ref_w  [64];
  logic [31:0] ref_k  [64];
  int n_hs, n_done, n_rd, rd_bad, wr_bad, hold_bad, rnd_bad, extra_bad, done_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule built straight from the padded block bytes
  function automatic void model(input int len);
    logic [7:0] blk [64];
    int l;
    logic [31:0] s0, s1;
    l = (len > 55) ? 55 : len;
    for (int i = 0; i < 64; i++) blk[i] = (i < l) ? msg_mem[i] : ((i == l) ? 8'h80 : 8'h00);
    blk[62] = 8'((l * 8) >> 8);
    blk[63] = 8'(l * 8);
    for (int t = 0; t < 16; t++) mw[t] = {blk[4*t], blk[4*t+1], blk[4*t+2], blk[4*t+3]};
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(mw[t-15], 7) ^ rotr(mw[t-15], 18) ^ (mw[t-15] >> 3);
      s1 = rotr(mw[t-2], 17) ^ rotr(mw[t-2], 19) ^ (mw[t-2] >> 10);
      mw[t] = s1 + mw[t-7] + s0 + mw[t-16];
    end
  endfunction

  function automatic int seq_diff(input bit vs_model);
    int d = 0;
    for (int t = 0; t < 64; t++) begin
      if (vs_model) begin
        if (cap_w[t] !== mw[t] || cap_k[t] !== kmem[t]) d++;
      end else begin
        if (cap_w[t] !== ref_w[t] || cap_k[t] !== ref_k[t]) d++;
      end
    end
    return d;
  endfunction

  task automatic load_mem(input bit abc, input logic [7:0] fill);
    for (int i = 0; i < 64; i++) begin
      if (abc) msg_mem[i] = (i < 3) ? 8'(8'h61 + i) : 8'hEE;
      else     msg_mem[i] = fill;
    end
  endtask

  // One go-to-done transaction; called and returning at a negedge
  task automatic run_txn(input int len, input bit rnd_ready, input bit go_noise);
    int cyc;
    bit stall;
    logic [31:0] hw, hk;
    logic [5:0]  hr;
    n_hs = 0; n_done = 0; n_rd = 0; rd_bad = 0; wr_bad = 0;
    hold_bad = 0; rnd_bad = 0; extra_bad = 0; done_cyc = -1;
    stall = 1'b0; hw = '0; hk = '0; hr = '0;
    for (int t = 0; t < 64; t++) begin cap_w[t] = 'x; cap_k[t] = 'x; end
    go = 1'b1; msg_length = 7'(len); ready = 1'b1;
    @(negedge clk);
    go = 1'b0; cyc = 1;
    while (done_cyc < 0 && cyc < 1000) begin
      if (dut__msg__write || dut__kmem__write) wr_bad++;
      if (dut__msg__enable) begin
        if (int'(dut__msg__address) != n_rd) rd_bad++;
        n_rd++;
      end
      if (dut__kmem__enable && int'(dut__kmem__address) != n_hs) rd_bad++;
      if (sched__xxx__done) begin n_done++; done_cyc = cyc; end
      if (sched__core__valid) begin
        if (stall && (sched__core__w !== hw || sched__core__k !== hk || sched__core__round !== hr))
          hold_bad++;
        go = go_noise && (sched__core__round == 6'd10);
        if (go_noise) msg_length = 7'd0;
        ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (ready) begin
          if (int'(sched__core__round) != n_hs) rnd_bad++;
          cap_w[sched__core__round] = sched__core__w;
          cap_k[sched__core__round] = sched__core__k;
          n_hs++;
          stall = 1'b0;
        end else begin
          stall = 1'b1;
          hw = sched__core__w; hk = sched__core__k; hr = sched__core__round;
        end
      end else begin
        go = 1'b0;
        ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    // Currently in DONE (or timed out): optionally pulse go, then watch for restarts
    go = go_noise;
    repeat (6) begin
      @(negedge clk);
      go = 1'b0;
      if (sched__xxx__done) n_done++;
      if (dut__msg__enable || sched__core__valid) extra_bad++;
    end
    ready = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " valid"}, 32'(sched__core__valid), 32'h0);
    chk({tag, " done"},  32'(sched__xxx__done), 32'h0);
    chk({tag, " w"},     sched__core__w, 32'h0);
    chk({tag, " k"},     sched__core__k, 32'h0);
    chk({tag, " round"}, 32'(sched__core__round), 32'h0);
    chk({tag, " mem ports"},
        32'({dut__msg__enable, dut__msg__address, dut__kmem__enable, dut__kmem__address,
             dut__msg__write, dut__kmem__write}), 32'h0);
  endtask

  initial begin
    int guard;
    vecs[0] = '{"abc",   3,  1'b1, 8'hEE, 3,  32'h61626380, 32'h0, 32'h0, 32'h00000018,
                32'h61626380, 32'h000F0000};
    vecs[1] = '{"len0",  0,  1'b0, 8'h5A, 0,  32'h80000000, 32'h0, 32'h0, 32'h0,
                32'h80000000, 32'h0};
    vecs[2] = '{"len55", 55, 1'b0, 8'h41, 55, 32'h41414141, 32'h41414180, 32'h0, 32'h000001B8,
                32'h5D7D7D7C, 32'h5E687D7C};
    vecs[3] = '{"len70", 70, 1'b0, 8'h41, 55, 32'h41414141, 32'h41414180, 32'h0, 32'h000001B8,
                32'h5D7D7D7C, 32'h5E687D7C};
    for (int i = 0; i < 64; i++) kmem[i] = 32'hC0DE0000 ^ (32'(i) * 32'h01030507);
    load_mem(1'b1, 8'h00);

    // Reset state, with go held high to show reset wins
    reset = 1'b1; go = 1'b1; msg_length = 7'd3;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0; go = 1'b0;
    @(negedge clk);
    chk("reset beats go", 32'({dut__msg__enable, sched__core__valid}), 32'h0);

    foreach (vecs[v]) begin
      load_mem(vecs[v].abc, vecs[v].fill);
      model(vecs[v].len);
      run_txn(vecs[v].len, 1'b0, 1'b0);
      chk({vecs[v].name, " msg reads"}, 32'(n_rd), 32'(vecs[v].exp_reads));
      chk({vecs[v].name, " addr order"}, 32'(rd_bad), 32'h0);
      chk({vecs[v].name, " write strobes"}, 32'(wr_bad), 32'h0);
      chk({vecs[v].name, " W0"},  cap_w[0],  vecs[v].w0);
      chk({vecs[v].name, " W13"}, cap_w[13], vecs[v].w13);
      chk({vecs[v].name, " W14"}, cap_w[14], vecs[v].w14);
      chk({vecs[v].name, " W15"}, cap_w[15], vecs[v].w15);
      chk({vecs[v].name, " W16"}, cap_w[16], vecs[v].w16);
      chk({vecs[v].name, " W17"}, cap_w[17], vecs[v].w17);
      chk({vecs[v].name, " K0"},  cap_k[0],  kmem[0]);
      chk({vecs[v].name, " handshakes"}, 32'(n_hs), 32'd64);
      chk({vecs[v].name, " round order"}, 32'(rnd_bad), 32'h0);
      chk({vecs[v].name, " model seq diffs"}, 32'(seq_diff(1'b1)), 32'h0);
      chk({vecs[v].name, " done pulses"}, 32'(n_done), 32'd1);
      chk({vecs[v].name, " go-to-done cycles"}, 32'(done_cyc), 32'd193);
      chk({vecs[v].name, " idle after done"}, 32'(extra_bad), 32'h0);
      if (v == 0) begin
        for (int t = 0; t < 64; t++) begin ref_w[t] = cap_w[t]; ref_k[t] = cap_k[t]; end
      end
    end

    // Random backpressure must not change the stream
    load_mem(1'b1, 8'h00);
    run_txn(3, 1'b1, 1'b0);
    chk("stall hold", 32'(hold_bad), 32'h0);
    chk("stall handshakes", 32'(n_hs), 32'd64);
    chk("stall seq diffs", 32'(seq_diff(1'b0)), 32'h0);
    chk("stall done pulses", 32'(n_done), 32'd1);

    // go pulsed during PRESENT and during DONE is ignored
    run_txn(3, 1'b0, 1'b1);
    chk("go noise seq diffs", 32'(seq_diff(1'b0)), 32'h0);
    chk("go noise done pulses", 32'(n_done), 32'd1);
    chk("go noise done cycle", 32'(done_cyc), 32'd193);
    chk("go in done ignored", 32'(extra_bad), 32'h0);

    // Reset while presenting round 20 aborts without a done pulse
    go = 1'b1; msg_length = 7'd3; ready = 1'b1;
    @(negedge clk);
    go = 1'b0;
    guard = 0;
    while (!(sched__core__valid && sched__core__round == 6'd20) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("reached round 20", 32'(sched__core__round), 32'd20);
    reset = 1'b1;
    @(negedge clk);
    chk_zero("mid-run reset");
    reset = 1'b0;
    n_done = 0;
    repeat (200) begin
      @(negedge clk);
      if (sched__xxx__done || sched__core__valid || dut__msg__enable) n_done++;
    end
    chk("no activity after abort", 32'(n_done), 32'h0);
    run_txn(3, 1'b0, 1'b0);
    chk("rerun W0", cap_w[0], 32'h61626380);
    chk("rerun W16", cap_w[16], 32'h61626380);
    chk("rerun seq diffs", 32'(seq_diff(1'b0)), 32'h0);
    chk("rerun done pulses", 32'(n_done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
